// File: rtl/spi_master_shift.sv
// SPI mode-0 master shift engine: serialises one word MSB first on mosi/sclk/cs_n
// and assembles the word returned on miso.
module spi_master_shift #(
  parameter int W_DATA  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_DATA-1:0] tx_data,
  output logic [W_DATA-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(W_DATA) + 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     phase, phase_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic [W_DATA-1:0] tx_shift, tx_shift_next;
  logic [W_DATA-1:0] rx_shift, rx_shift_next;
  logic [W_DATA-1:0] rx_data_next;
  logic              busy_next, done_next, sclk_next, cs_n_next;
  logic              phase_end;

  // mosi is the MSB of a register, so it only moves when the shifter does.
  assign mosi      = tx_shift[W_DATA-1];
  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      bit_cnt  <= bit_cnt_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      busy     <= busy_next;
      done     <= done_next;
      sclk     <= sclk_next;
      cs_n     <= cs_n_next;
    end
  end

  always_comb begin
    state_next    = state;
    phase_next    = phase_end ? '0 : phase + PW'(1);
    bit_cnt_next  = bit_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    busy_next     = busy;
    done_next     = 1'b0;
    sclk_next     = sclk;
    cs_n_next     = cs_n;

    unique case (state)
      IDLE: begin
        phase_next = '0;
        if (start) begin
          state_next    = LEAD;
          tx_shift_next = tx_data;
          bit_cnt_next  = '0;
          cs_n_next     = 1'b0;
          busy_next     = 1'b1;
        end
      end
      LEAD: begin
        if (phase_end) begin
          state_next    = HIGH;
          sclk_next     = 1'b1;
          rx_shift_next = {rx_shift[W_DATA-2:0], miso};
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_next = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_next = TRAIL;
          end else begin
            state_next    = LOW;
            tx_shift_next = {tx_shift[W_DATA-2:0], 1'b0};
            bit_cnt_next  = bit_cnt + BW'(1);
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          state_next    = HIGH;
          sclk_next     = 1'b1;
          rx_shift_next = {rx_shift[W_DATA-2:0], miso};
        end
      end
      TRAIL: begin
        if (phase_end) begin
          state_next   = IDLE;
          cs_n_next    = 1'b1;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          rx_data_next = rx_shift;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_shift.sv
// Directed bench for spi_master_shift: a 32-bit/CLK_DIV=2 instance and an
// 8-bit/CLK_DIV=1 instance, checked against hand-computed values.
module tb_spi_master_shift;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, busy_a, done_a, sclk_a, mosi_a, cs_n_a, miso_a;
  logic [31:0] tx_a, rx_a;
  logic        loop_a, fix_a;
  assign miso_a = loop_a ? mosi_a : fix_a;

  logic       start_b, busy_b, done_b, sclk_b, mosi_b, cs_n_b, miso_b;
  logic [7:0] tx_b, rx_b;
  assign miso_b = mosi_b;

  spi_master_shift #(.W_DATA(32), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .rx_data(rx_a),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a),
    .miso(miso_a)
  );

  spi_master_shift #(.W_DATA(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .rx_data(rx_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b),
    .miso(miso_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge monitors on pre-edge output values.
  int          rise_a = 0, busy_cnt_a = 0, done_cnt_a = 0;
  int          rise_b = 0, tog_b = 0, busy_cnt_b = 0;
  logic        sclk_prev_a = 1'b0, sclk_prev_b = 1'b0;
  logic [31:0] mosi_cap = '0;

  always @(posedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (done_a) done_cnt_a++;
    if (sclk_a && !sclk_prev_a) begin
      rise_a++;
      mosi_cap = {mosi_cap[30:0], mosi_a};
    end
    sclk_prev_a = sclk_a;
    if (busy_b) busy_cnt_b++;
    if (sclk_b && !sclk_prev_b) rise_b++;
    if (sclk_b != sclk_prev_b) tog_b++;
    sclk_prev_b = sclk_b;
  end

  task automatic go_a(input logic [31:0] tx);
    start_a = 1'b1;
    tx_a    = tx;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (sel ? done_b : done_a) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  int b0, r0, d0, t0;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_a = '0; tx_b = '0;
    loop_a = 1'b1; fix_a = 1'b0;
    #12;
    check("rst_sclk", 64'(sclk_a), 64'd0);
    check("rst_cs_n", 64'(cs_n_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rx",   64'(rx_a),   64'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // Loopback, MSB-first and timing
    b0 = busy_cnt_a; r0 = rise_a; d0 = done_cnt_a;
    go_a(32'hA5A5_0F0F);
    wait_done(1'b0, 200, "lb_timeout");
    check("lb_rx",    64'(rx_a), 64'hA5A5_0F0F);
    check("lb_rises", 64'(rise_a - r0), 64'd32);
    check("lb_busy",  64'(busy_cnt_a - b0), 64'd130);
    check("lb_mosi",  64'(mosi_cap), 64'hA5A5_0F0F);
    @(posedge clk); #1;
    check("lb_done_drop", 64'(done_a), 64'd0);
    check("lb_done_cnt",  64'(done_cnt_a - d0), 64'd1);

    // Tied miso
    loop_a = 1'b0; fix_a = 1'b1;
    go_a(32'h0000_0000);
    wait_done(1'b0, 200, "t1_timeout");
    check("t1_rx",   64'(rx_a), 64'hFFFF_FFFF);
    check("t1_mosi", 64'(mosi_cap), 64'd0);
    fix_a = 1'b0;
    go_a(32'hFFFF_FFFF);
    wait_done(1'b0, 200, "t0_timeout");
    check("t0_rx", 64'(rx_a), 64'd0);

    // Start while busy ignored, then back-to-back start in the done cycle
    loop_a = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt_a;
    go_a(32'h3C3C_C3C3);
    repeat (9) @(posedge clk);
    #1 start_a = 1'b1; tx_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done(1'b0, 200, "ign_timeout");
    check("ign_rx", 64'(rx_a), 64'h3C3C_C3C3);
    check("b2b_cs_hi", 64'(cs_n_a), 64'd1);
    go_a(32'h0F1E_2D3C);
    check("b2b_cs_lo", 64'(cs_n_a), 64'd0);
    check("b2b_busy",  64'(busy_a), 64'd1);
    check("b2b_done",  64'(done_a), 64'd0);
    check("ign_done_cnt", 64'(done_cnt_a - d0), 64'd1);
    wait_done(1'b0, 200, "b2b_timeout");
    check("b2b_rx", 64'(rx_a), 64'h0F1E_2D3C);

    // Asynchronous abort during bit 17
    @(posedge clk); #1;
    go_a(32'h5555_AAAA);
    repeat (71) @(posedge clk);
    #1;
    check("ab_busy_pre", 64'(busy_a), 64'd1);
    d0 = done_cnt_a;
    #3 rst = 1'b1;
    #1;
    check("ab_sclk", 64'(sclk_a), 64'd0);
    check("ab_cs_n", 64'(cs_n_a), 64'd1);
    check("ab_busy", 64'(busy_a), 64'd0);
    check("ab_done", 64'(done_a), 64'd0);
    check("ab_rx",   64'(rx_a),   64'd0);
    check("ab_mosi", 64'(mosi_a), 64'd0);
    #2 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("ab_no_done", 64'(done_cnt_a - d0), 64'd0);
    go_a(32'h1234_5678);
    wait_done(1'b0, 200, "ar_timeout");
    check("ar_rx", 64'(rx_a), 64'h1234_5678);

    // 8-bit, CLK_DIV=1 loopback
    @(posedge clk); #1;
    b0 = busy_cnt_b; r0 = rise_b; t0 = tog_b;
    start_b = 1'b1; tx_b = 8'h81;
    @(posedge clk);
    #1 start_b = 1'b0;
    wait_done(1'b1, 50, "b_timeout");
    check("b_rx",    64'(rx_b), 64'h81);
    check("b_busy",  64'(busy_cnt_b - b0), 64'd17);
    check("b_rises", 64'(rise_b - r0), 64'd8);
    check("b_tog",   64'(tog_b - t0), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_shift.md
# spi_master_shift

SPI master shift engine: serialises one CPU word onto MOSI/SCLK/CS_n and assembles the word returned on MISO. It sits directly downstream of the SPI coprocessor register file. The transmit word written by MTC0 arrives on `tx_data` with a `start` strobe. The received word on `rx_data` is written back into the register file for MFC0. The engine is fixed to SPI mode 0 (CPOL=0, CPHA=0), shifts MSB first, and moves one word per transaction.

## Interface
Parameters:
- `W_DATA`, default 32 (`W_CPU`): word length in bits; must be at least 2.
- `CLK_DIV`, default 4: clk cycles per SCLK half-period; must be at least 1.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transaction; sampled only in IDLE.
- `tx_data`  in  W_DATA  word to transmit; captured on the accepted `start` edge.
- `rx_data`  out  W_DATA  last completed received word; held until the next completion.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `sclk`  out  1  SPI clock; idles low.
- `mosi`  out  1  serial data out.
- `cs_n`  out  1  active-low chip select.
- `miso`  in  1  serial data in; the system synchroniser is external to this block.

## Operation
- Reset (asynchronous) forces: state IDLE, `sclk`=0, `cs_n`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, shift registers 0, counters 0.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL.
  - IDLE: when `start`=1 at a clk edge, latch `tx_data` into the tx shifter, clear the bit counter, go to LEAD. `cs_n`=0, `busy`=1, `mosi`=tx_data[W_DATA-1] take effect from the next cycle.
  - LEAD: `cs_n` low, `sclk` low, for CLK_DIV cycles, then go to HIGH.
  - HIGH: `sclk`=1 for CLK_DIV cycles. On the edge entering HIGH, sample `miso` into rx_shift[0] with the rest shifted left, so the MSB is received first. On exit:
    - if the bit counter equals W_DATA-1, go to TRAIL;
    - otherwise go to LOW.
  - LOW: `sclk`=0 for CLK_DIV cycles. On the edge entering LOW, shift tx left so `mosi` presents the next bit, and increment the bit counter. Then go to HIGH.
  - TRAIL: `sclk`=0, `cs_n` still low, `mosi` holds the last bit, for CLK_DIV cycles. On exit, in a single edge:
    - `cs_n`=1, `busy`=0, `done`=1;
    - `rx_data` ← rx_shift;
    - go to IDLE.
- `done` drops on the following edge unless a new completion occurs, which is impossible at that point.
- `start` while busy is ignored: no queueing, and the latched tx word is unaffected.
- A `start` in the same cycle that `done`=1 is accepted, because the state is IDLE. `done` still pulses for exactly one cycle.
- `tx_data` changes after acceptance have no effect on the transaction in flight.
- A phase counter (width clog2(CLK_DIV)+1) counts 0..CLK_DIV-1 within each phase and wraps to 0 on every phase change.
- The bit counter (width clog2(W_DATA)+1) never exceeds W_DATA-1.
- Reset mid-transaction aborts immediately, asynchronously: all reset values apply and no `done` pulse is produced. `rx_data` returns to 0.

## Timing
- `start` accepted at edge T:
  - `cs_n` falls and `busy` rises after edge T.
  - First `sclk` rise after edge T+CLK_DIV.
- Exactly W_DATA rising `sclk` edges per transaction, each high for CLK_DIV clks and each low for CLK_DIV clks between them.
- `busy` is high for CLK_DIV·(2·W_DATA+1) cycles:
  - LEAD: CLK_DIV;
  - W_DATA HIGH phases;
  - W_DATA-1 LOW phases;
  - TRAIL: CLK_DIV.
- Setup and hold: `mosi` changes only on `sclk` falling edges or at LEAD entry. It is stable for at least CLK_DIV clks before and after every `sclk` rise.
- `rx_data` is valid in the same cycle as `done`=1 and stays stable until the next `done`.
- `sclk` and `cs_n` are registered outputs, so they are glitch-free.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> outputs immediately show `sclk`=0, `cs_n`=1, `busy`=0, `done`=0, `rx_data`=0.
- Loopback (`miso`=`mosi`), CLK_DIV=2, `tx_data`=32'hA5A5_0F0F -> 32 `sclk` rises; `busy` high for 130 cycles; one `done` pulse; `rx_data`=32'hA5A5_0F0F. Bit order checked MSB first on `mosi`.
- `miso` tied 1 with `tx_data`=0 -> `rx_data`=32'hFFFF_FFFF and `mosi` stays 0. `miso` tied 0 with `tx_data`=32'hFFFF_FFFF -> `rx_data`=0.
- `start` pulsed again at cycle 10 of a transaction, with `tx_data` also changed -> ignored: the first word completes unchanged and only one `done` pulse occurs. Then `start` asserted in the `done` cycle -> a second transaction begins with no idle gap; `cs_n` stays high for exactly one cycle.
- Reset at bit 17 of a transfer -> no `done` pulse, `cs_n`=1 at once. A following transaction with 32'h1234_5678 in loopback returns 32'h1234_5678.
- CLK_DIV=1 with W_DATA=8, loopback 8'h81 -> `sclk` toggles every clk; `busy`=17 cycles; `rx_data`=8'h81.
